// File: rtl/pc_fetch_unit.sv
// Fetch unit: holds the architectural PC, fetches one instruction at a time over req/gnt/rvalid
// and commits the branch logic's next PC on retire. Optional alignment fault: FETCH_ALIGN_CHECK_EN.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   output logic [31:0]      PC,
   input  logic [31:0]      NEXT_PC,
   input  logic             PC_LOAD,
   output logic             IMEM_REQ,
   output logic [31:0]      IMEM_ADDR,
   input  logic             IMEM_GNT,
   input  logic             IMEM_RVALID,
   input  logic [31:0]      IMEM_RDATA,
   output logic [31:0]      INSTR,
   output logic             INSTR_VALID,
   output logic [CNT_W-1:0] RET_CNT,
   output logic             FETCH_FAULT
);

   localparam int unsigned XLEN       = 32;
   localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;
   localparam logic [XLEN-1:0] WMASK  = 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_e;
`else
   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_e;
`endif

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              req_q, req_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fault_q, fault_d;

   // Next-state and registered-output logic; IMEM_REQ is high exactly while in REQ
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      case (state_q)
         S_BOOT: state_d = S_REQ;
         S_REQ: begin
            if (IMEM_GNT) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (IMEM_RVALID) begin
               instr_d = IMEM_RDATA;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (PC_LOAD) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
               pc_d    = NEXT_PC;
               if (NEXT_PC[1:0] != 2'b00) begin
                  fault_d = 1'b1;
                  state_d = S_FAULT;
               end
`else
               pc_d    = NEXT_PC & WMASK;
`endif
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         S_FAULT: state_d = S_FAULT;
`endif
         default: state_d = S_BOOT;
      endcase
      req_d = (state_d == S_REQ);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VECTOR;
         instr_q <= NOP;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign PC          = pc_q;
   assign IMEM_ADDR   = pc_q;
   assign IMEM_REQ    = req_q;
   assign INSTR       = instr_q;
   assign INSTR_VALID = valid_q;
   assign RET_CNT     = cnt_q;
   assign FETCH_FAULT = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: bench-driven memory, scoreboard of fetched words.
module tb_pc_fetch_unit;

   localparam int unsigned CNT_W        = 4;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   logic             CLK;
   logic             RST_N;
   logic [31:0]      PC;
   logic [31:0]      NEXT_PC;
   logic             PC_LOAD;
   logic             IMEM_REQ;
   logic [31:0]      IMEM_ADDR;
   logic             IMEM_GNT;
   logic             IMEM_RVALID;
   logic [31:0]      IMEM_RDATA;
   logic [31:0]      INSTR;
   logic             INSTR_VALID;
   logic [CNT_W-1:0] RET_CNT;
   logic             FETCH_FAULT;

   int               n_checks = 0;
   int               n_errors = 0;
   logic [31:0]      exp_q[$];
   logic [31:0]      pc_m;
   logic [CNT_W-1:0] cnt_m;
   logic             fault_m;

   pc_fetch_unit #(.RESET_VECTOR(RESET_VECTOR), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .PC(PC), .NEXT_PC(NEXT_PC), .PC_LOAD(PC_LOAD),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
      .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .INSTR(INSTR),
      .INSTR_VALID(INSTR_VALID), .RET_CNT(RET_CNT), .FETCH_FAULT(FETCH_FAULT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_pc"},    PC, RESET_VECTOR);
      check_eq({tag, "_addr"},  IMEM_ADDR, RESET_VECTOR);
      check_eq({tag, "_req"},   32'(IMEM_REQ), 32'd0);
      check_eq({tag, "_instr"}, INSTR, 32'h0000_0013);
      check_eq({tag, "_valid"}, 32'(INSTR_VALID), 32'd0);
      check_eq({tag, "_cnt"},   32'(RET_CNT), 32'd0);
      check_eq({tag, "_fault"}, 32'(FETCH_FAULT), 32'd0);
   endtask

   task automatic reset_model();
      pc_m    = RESET_VECTOR;
      cnt_m   = '0;
      fault_m = 1'b0;
      exp_q.delete();
   endtask

   // Reset for two cycles, release on a falling edge; returns at cycle 1 after release
   task automatic apply_reset();
      RST_N = 1'b0; PC_LOAD = 1'b0; NEXT_PC = '0;
      IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'hDEAD_BEEF;
      reset_model();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      check_reset_outputs("boot");
      @(negedge CLK);
   endtask

   // One fetch: wait for REQ, grant after gnt_dly cycles, return data rv_dly cycles after GNT+1
   task automatic do_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data,
                           input bit poke, output int wait_n);
      wait_n = 0;
      while (!IMEM_REQ && wait_n < 20) begin
         @(negedge CLK);
         wait_n++;
      end
      check_eq("req_seen", 32'(IMEM_REQ), 32'd1);
      check_eq("req_addr", IMEM_ADDR, pc_m);
      for (int i = 0; i < gnt_dly; i++) begin
         PC_LOAD = poke; NEXT_PC = 32'h0000_0888;
         @(negedge CLK);
         check_eq("req_addr_stable", IMEM_ADDR, pc_m);
         check_eq("req_held", 32'(IMEM_REQ), 32'd1);
         check_eq("req_pc_kept", PC, pc_m);
         check_eq("req_cnt_kept", 32'(RET_CNT), 32'(cnt_m));
      end
      // Response in the GNT cycle must be ignored
      IMEM_GNT = 1'b1; IMEM_RVALID = 1'b1; IMEM_RDATA = ~data;
      exp_q.push_back(data);
      @(negedge CLK);
      IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'hDEAD_BEEF;
      check_eq("req_drop", 32'(IMEM_REQ), 32'd0);
      check_eq("wait_valid", 32'(INSTR_VALID), 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
         PC_LOAD = poke; NEXT_PC = 32'h0000_0888;
         @(negedge CLK);
         check_eq("wait_valid", 32'(INSTR_VALID), 32'd0);
         check_eq("wait_req", 32'(IMEM_REQ), 32'd0);
         check_eq("wait_pc_kept", PC, pc_m);
         check_eq("wait_cnt_kept", 32'(RET_CNT), 32'(cnt_m));
      end
      PC_LOAD = 1'b0;
      IMEM_RVALID = 1'b1; IMEM_RDATA = data;
      @(negedge CLK);
      IMEM_RVALID = 1'b0; IMEM_RDATA = 32'hDEAD_BEEF;
      check_eq("hold_valid", 32'(INSTR_VALID), 32'd1);
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'd0, 32'd1);
      else check_eq("instr", INSTR, exp_q.pop_front());
      // Extra response while holding must not disturb the held word
      IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hBAD0_BAD0;
      @(negedge CLK);
      IMEM_RVALID = 1'b0; IMEM_RDATA = 32'hDEAD_BEEF;
      check_eq("hold_instr_stable", INSTR, data);
      check_eq("hold_valid_stable", 32'(INSTR_VALID), 32'd1);
   endtask

   task automatic retire(input logic [31:0] npc);
      NEXT_PC = npc; PC_LOAD = 1'b1;
      @(negedge CLK);
      PC_LOAD = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_m = npc;
      if (npc[1:0] != 2'b00) fault_m = 1'b1;
`else
      pc_m = npc & 32'hFFFF_FFFC;
`endif
      cnt_m = cnt_m + 1'b1;
      check_eq("ret_pc", PC, pc_m);
      check_eq("ret_addr", IMEM_ADDR, pc_m);
      check_eq("ret_cnt", 32'(RET_CNT), 32'(cnt_m));
      check_eq("ret_valid", 32'(INSTR_VALID), 32'd0);
      check_eq("ret_req", 32'(IMEM_REQ), 32'(!fault_m));
      check_eq("ret_fault", 32'(FETCH_FAULT), 32'(fault_m));
   endtask

   initial begin
      int n;
      apply_reset();
      do_fetch(0, 0, 32'h0000_0013, 1'b0, n);
      check_eq("req_latency", 32'(n), 32'd0);

      retire(32'h0000_0004);
      do_fetch(3, 2, 32'h00A0_0093, 1'b1, n);
      check_eq("req_after_load", 32'(n), 32'd0);

      for (int i = 0; i < 14; i++) begin
         retire(pc_m + 32'd4);
         do_fetch(int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), $urandom(), 1'b0, n);
      end
      retire(pc_m + 32'd4);
      check_eq("cnt_wrap", 32'(RET_CNT), 32'd0);
      do_fetch(0, 0, 32'h0010_0113, 1'b0, n);

      retire(32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
      for (int i = 0; i < 4; i++) begin
         PC_LOAD = 1'b1; NEXT_PC = 32'h0000_0200;
         @(negedge CLK);
         check_eq("fault_no_req", 32'(IMEM_REQ), 32'd0);
         check_eq("fault_sticky", 32'(FETCH_FAULT), 32'd1);
         check_eq("fault_pc_kept", PC, pc_m);
         check_eq("fault_cnt_kept", 32'(RET_CNT), 32'(cnt_m));
      end
      PC_LOAD = 1'b0;
      apply_reset();
      do_fetch(0, 0, 32'h0000_0013, 1'b0, n);
`else
      check_eq("align_pc", PC, 32'h0000_0100);
      do_fetch(1, 1, 32'h0020_0193, 1'b0, n);
`endif

      // Reset while a fetch is outstanding in WAIT
      retire(pc_m + 32'd4);
      IMEM_GNT = 1'b1;
      @(negedge CLK);
      IMEM_GNT = 1'b0;
      check_eq("pre_rst_req", 32'(IMEM_REQ), 32'd0);
      #1 RST_N = 1'b0;
      #1 check_reset_outputs("async_rst");
      reset_model();
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      do_fetch(0, 0, 32'h0030_0213, 1'b0, n);
      check_eq("refetch_latency", 32'(n), 32'd0);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path. Holds the architectural PC and drives it to the branch logic, which returns the next PC (PC+4 or PC+IMM).
- Fetches the instruction at the current PC from instruction memory over a req/gnt/rvalid handshake and presents it to decode.
- Commits the branch logic's next PC when the execute stage retires the instruction.
- Non-pipelined: exactly one fetch outstanding, so one instruction is in flight at a time.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  : system clock, rising edge.
- RST_N  in  1  : asynchronous active-low reset.
- PC  out  32  : current PC, fed to the branch logic PC input.
- NEXT_PC  in  32  : next PC from the branch logic INCR output.
- PC_LOAD  in  1  : execute stage retires the presented instruction; commit NEXT_PC.
- IMEM_REQ  out  1  : fetch request.
- IMEM_ADDR  out  32  : fetch address, always equal to PC.
- IMEM_GNT  in  1  : memory accepted the request.
- IMEM_RVALID  in  1  : read data valid.
- IMEM_RDATA  in  32  : instruction word.
- INSTR  out  32  : held instruction, to decode.
- INSTR_VALID  out  1  : INSTR is valid.
- RET_CNT  out  CNT_W  : retired-instruction count.
- FETCH_FAULT  out  1  : misalignment fault; only present with the optional feature, otherwise tied 0.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N. All state resets asynchronously.
- Reset values:
  - PC = RESET_VECTOR
  - state = BOOT
  - IMEM_REQ = 0
  - INSTR = 32'h0000_0013 (NOP)
  - INSTR_VALID = 0
  - RET_CNT = 0
  - FETCH_FAULT = 0
- Outputs are registered except IMEM_ADDR, which is wired to PC.
- FSM states: BOOT, REQ, WAIT, HOLD, FAULT (FAULT only with the optional feature).
- BOOT: lasts one cycle after reset deassert, then goes to REQ. IMEM_REQ = 0.
- REQ: IMEM_REQ = 1; IMEM_ADDR is stable while in this state.
  - IMEM_GNT = 1 -> WAIT; IMEM_REQ drops the next cycle.
  - IMEM_GNT = 0 -> stay in REQ.
  - IMEM_RVALID in REQ is ignored.
- WAIT: IMEM_REQ = 0.
  - IMEM_RVALID = 1 -> capture INSTR <= IMEM_RDATA, set INSTR_VALID = 1, go to HOLD.
  - The earliest RVALID accepted is the cycle after GNT; RVALID in the same cycle as GNT is not accepted.
- HOLD: INSTR and INSTR_VALID are stable until PC_LOAD.
  - PC_LOAD = 1 -> PC <= NEXT_PC, INSTR_VALID <= 0, RET_CNT <= RET_CNT + 1, go to REQ.
  - RET_CNT wraps modulo 2^CNT_W.
- PC_LOAD outside HOLD is ignored: no PC change, no count.
- Latency:
  - PC_LOAD to IMEM_REQ high: 1 cycle.
  - Zero-wait memory (GNT same cycle as REQ, RVALID next cycle): INSTR_VALID rises 2 cycles after REQ rises.
  - Minimum instruction period: 3 cycles.
- PC arithmetic: 32-bit wrap is the branch logic's responsibility; this block stores NEXT_PC verbatim, subject to the optional feature.
- Mid-operation reset: an outstanding fetch is abandoned. Instruction memory shares RST_N, so no stale RVALID follows reset.
- IMEM_RDATA is sampled only on the accepted RVALID cycle.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - PC_LOAD in HOLD with NEXT_PC[1:0] != 2'b00 -> PC still loads NEXT_PC, INSTR_VALID <= 0, FETCH_FAULT <= 1, go to FAULT.
  - RET_CNT still increments.
  - FAULT is sticky until reset: no IMEM_REQ, PC_LOAD ignored.
- Not defined:
  - PC <= {NEXT_PC[31:2], 2'b00} (low bits forced to 0).
  - FETCH_FAULT tied 0, and no FAULT state exists.

Test Plan:
- Reset, then zero-wait memory returning 32'h0000_0013 -> IMEM_REQ at cycle 1 after deassert with IMEM_ADDR = 0; INSTR_VALID at cycle 3 with INSTR = 32'h13.
- HOLD, NEXT_PC = 32'h0000_0004, pulse PC_LOAD -> next cycle PC = 4, RET_CNT = 1, IMEM_REQ = 1 with IMEM_ADDR = 4.
- GNT held low 3 cycles, then RVALID delayed 2 cycles -> IMEM_ADDR stable throughout; exactly one capture; INSTR_VALID stays 0 until RVALID.
- PC_LOAD pulsed during REQ and WAIT -> PC and RET_CNT unchanged.
- RET_CNT forced to all-ones (CNT_W = 4, value 15), then one retire -> RET_CNT = 0.
- NEXT_PC = 32'h0000_0102 on PC_LOAD:
  - with FETCH_ALIGN_CHECK_EN -> FETCH_FAULT = 1 and no further IMEM_REQ.
  - without -> PC = 32'h100 and fetch proceeds.
- Assert RST_N low during WAIT -> all outputs at reset values immediately (asynchronous); refetch from RESET_VECTOR after release.
